// File: rtl/uart_pkg.sv
// Shared definitions for the UART hex feeder: ASCII constants, formatter
// state encoding and the nibble-to-ASCII helper.
package uart_pkg;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_A  = 8'h41;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EMIT = 2'd1,
    ST_GAP  = 2'd2,
    ST_WAIT = 2'd3
  } feeder_state_e;

  // Uppercase hex digit for one nibble.
  function automatic logic [7:0] nibble_to_ascii(input logic [3:0] nib);
    logic [7:0] ext;
    ext = {4'h0, nib};
    if (nib < 4'd10) begin
      return ASCII_0 + ext;
    end
    return ASCII_A + ext - 8'd10;
  endfunction

endpackage

// File: rtl/uart_hex_tx_feeder_if.sv
// Word input handshake plus transmitter enable/busy/data side of the feeder.
interface uart_hex_tx_feeder_if #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4
);

  logic                          in_valid;
  logic                          in_ready;
  logic [DATA_WIDTH-1:0]         in_data;
  logic                          tx_en;
  logic [7:0]                    tx_data;
  logic                          tx_busy;
  logic [$clog2(FIFO_DEPTH):0]   fifo_level;
  logic                          idle;

  // Upstream producer and transmitter model side.
  modport master (
    output in_valid, in_data, tx_busy,
    input  in_ready, tx_en, tx_data, fifo_level, idle
  );

  // Feeder side.
  modport slave (
    input  in_valid, in_data, tx_busy,
    output in_ready, tx_en, tx_data, fifo_level, idle
  );

endinterface

// File: rtl/sync_fifo.sv
// Small synchronous word FIFO with occupancy count; no write-through bypass,
// so a full FIFO refuses a push even when it is popped in the same cycle.
module sync_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          push,
  input  logic [DATA_WIDTH-1:0]         push_data,
  input  logic                          pop,
  output logic [DATA_WIDTH-1:0]         pop_data,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   level
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [AW:0]           count_q, count_d;
  logic                  do_push;
  logic                  do_pop;

  assign full     = (count_q == (AW+1)'(FIFO_DEPTH));
  assign empty    = (count_q == '0);
  assign level    = count_q;
  assign pop_data = mem_q[rd_ptr_q];
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;

  // Power-of-two depth lets the pointers wrap by natural overflow.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/uart_hex_tx_feeder.sv
// Buffers binary words and prints each as uppercase ASCII hex (MSB nibble
// first, optional CR LF) one byte at a time into a UART transmitter.
module uart_hex_tx_feeder
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int FIFO_DEPTH  = 4,
  parameter int APPEND_CRLF = 1
) (
  input logic                  clk,
  input logic                  resetn,
  uart_hex_tx_feeder_if.slave  bus
);

  localparam int NDIG  = DATA_WIDTH / 4;
  localparam int NCHAR = NDIG + ((APPEND_CRLF != 0) ? 2 : 0);
  localparam int IDX_W = $clog2(NDIG + 2);
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  feeder_state_e         state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [IDX_W-1:0]      char_idx_q, char_idx_d;

  logic                  fifo_push;
  logic                  fifo_pop;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_rd_data;
  logic [LVL_W-1:0]      fifo_level;
  logic                  is_digit;
  logic                  tx_en_raw;
  logic [7:0]            cur_char;

  sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .resetn    (resetn),
    .push      (fifo_push),
    .push_data (bus.in_data),
    .pop       (fifo_pop),
    .pop_data  (fifo_rd_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  assign fifo_push      = bus.in_valid && !fifo_full;
  assign bus.in_ready   = !fifo_full;
  assign bus.fifo_level = fifo_level;
  assign bus.idle       = fifo_empty && (state_q == ST_IDLE);
  assign is_digit       = (char_idx_q < IDX_W'(NDIG));

  // Character selection depends only on registered state, keeping tx_busy
  // out of the tx_data path.
  always_comb begin
    cur_char = nibble_to_ascii(shift_q[DATA_WIDTH-1 -: 4]);
    if (APPEND_CRLF != 0) begin
      if (char_idx_q == IDX_W'(NDIG)) begin
        cur_char = ASCII_CR;
      end else if (char_idx_q == IDX_W'(NDIG + 1)) begin
        cur_char = ASCII_LF;
      end
    end
  end

  assign bus.tx_data = (state_q == ST_EMIT) ? cur_char : 8'h00;
  assign bus.tx_en   = resetn && tx_en_raw;

  // GAP exists because the transmitter's busy flag only rises the cycle
  // after tx_en; WAIT then blocks until that byte has actually gone out.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    char_idx_d = char_idx_q;
    fifo_pop   = 1'b0;
    tx_en_raw  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          shift_d    = fifo_rd_data;
          char_idx_d = '0;
          state_d    = ST_EMIT;
        end
      end
      ST_EMIT: begin
        if (!bus.tx_busy) begin
          tx_en_raw = 1'b1;
          state_d   = ST_GAP;
        end
      end
      ST_GAP: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (!bus.tx_busy) begin
          if (char_idx_q == IDX_W'(NCHAR - 1)) begin
            state_d = ST_IDLE;
          end else begin
            char_idx_d = char_idx_q + 1'b1;
            if (is_digit) begin
              shift_d = shift_q << 4;
            end
            state_d = ST_EMIT;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= ST_IDLE;
      shift_q    <= '0;
      char_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      char_idx_q <= char_idx_d;
    end
  end

endmodule

// File: tb/tb_uart_hex_tx_feeder.sv
// Bench for uart_hex_tx_feeder: a busy-flag transmitter model per instance and
// a byte-stream reference built from accepted words with a hex lookup string.
module tb_uart_hex_tx_feeder;

  typedef logic [7:0] byte_q_t [$];

  logic clk;
  logic resetn;

  uart_hex_tx_feeder_if #(.DATA_WIDTH(32), .FIFO_DEPTH(4)) bus1 ();
  uart_hex_tx_feeder_if #(.DATA_WIDTH(32), .FIFO_DEPTH(4)) bus2 ();

  uart_hex_tx_feeder #(.DATA_WIDTH(32), .FIFO_DEPTH(4), .APPEND_CRLF(1)) dut1 (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus1)
  );

  uart_hex_tx_feeder #(.DATA_WIDTH(32), .FIFO_DEPTH(4), .APPEND_CRLF(0)) dut2 (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus2)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  byte_q_t exp1, exp2, log2;
  int      en_times1 [$];
  int      en_count1 = 0, en_count2 = 0;
  logic    prev_en1 = 1'b0, prev_en2 = 1'b0;
  logic [7:0] exp_b;

  int b1_len = 3;
  bit b1_rand = 1'b0;
  bit hold1 = 1'b0;
  int cnt1 = 0, cnt2 = 0;
  logic en1_s, en2_s;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Expected bytes for one word, rendered through a lookup string.
  function automatic byte_q_t render(input logic [31:0] w, input bit crlf);
    byte_q_t r;
    string hex;
    hex = "0123456789ABCDEF";
    for (int i = 7; i >= 0; i--) begin
      r.push_back(hex[int'((w >> (4 * i)) & 32'hF)]);
    end
    if (crlf) begin
      r.push_back(8'h0D);
      r.push_back(8'h0A);
    end
    return r;
  endfunction

  // Transmitter models: busy rises the cycle after tx_en and lasts a few cycles.
  always @(posedge clk) begin
    en1_s = bus1.tx_en;
    #1;
    if (en1_s) cnt1 = b1_rand ? int'($urandom_range(1, 6)) : b1_len;
    else if (cnt1 > 0) cnt1--;
    bus1.tx_busy = hold1 || (cnt1 > 0);
  end

  always @(posedge clk) begin
    en2_s = bus2.tx_en;
    #1;
    if (en2_s) cnt2 = 3;
    else if (cnt2 > 0) cnt2--;
    bus2.tx_busy = (cnt2 > 0);
  end

  // Stream monitors: record accepted words, check every emitted byte.
  always @(negedge clk) begin
    if (!resetn) exp1.delete();
    else if (bus1.in_valid && bus1.in_ready) exp1 = {exp1, render(bus1.in_data, 1'b1)};
    if (bus1.tx_en) begin
      checks++;
      if (prev_en1 || bus1.tx_busy) begin
        errors++;
        $display("[TB] FAIL dut1 tx_en_pulse: prev_en=%0b busy=%0b, required 0/0", prev_en1, bus1.tx_busy);
      end
      checks++;
      if (exp1.size() == 0) begin
        errors++;
        $display("[TB] FAIL dut1 unexpected_byte: got %h, required no tx_en", bus1.tx_data);
      end else begin
        exp_b = exp1.pop_front();
        if (bus1.tx_data !== exp_b) begin
          errors++;
          $display("[TB] FAIL dut1 tx_data: got %h required %h", bus1.tx_data, exp_b);
        end
      end
      en_times1.push_back(cyc);
      en_count1++;
    end
    prev_en1 = bus1.tx_en;
  end

  always @(negedge clk) begin
    if (!resetn) exp2.delete();
    else if (bus2.in_valid && bus2.in_ready) exp2 = {exp2, render(bus2.in_data, 1'b0)};
    if (bus2.tx_en) begin
      checks++;
      if (prev_en2 || bus2.tx_busy) begin
        errors++;
        $display("[TB] FAIL dut2 tx_en_pulse: prev_en=%0b busy=%0b, required 0/0", prev_en2, bus2.tx_busy);
      end
      checks++;
      if (exp2.size() == 0) begin
        errors++;
        $display("[TB] FAIL dut2 unexpected_byte: got %h, required no tx_en", bus2.tx_data);
      end else begin
        exp_b = exp2.pop_front();
        if (bus2.tx_data !== exp_b) begin
          errors++;
          $display("[TB] FAIL dut2 tx_data: got %h required %h", bus2.tx_data, exp_b);
        end
      end
      log2.push_back(bus2.tx_data);
      en_count2++;
    end
    prev_en2 = bus2.tx_en;
  end

  task automatic push_word1(input logic [31:0] w);
    int n = 0;
    @(posedge clk); #1;
    bus1.in_valid = 1'b1;
    bus1.in_data  = w;
    @(negedge clk);
    while (!bus1.in_ready && n < 500) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    bus1.in_valid = 1'b0;
    if (n >= 500) begin
      checks++; errors++;
      $display("[TB] FAIL dut1 push_timeout: in_ready=0 for %0d cycles, required 1", n);
    end
  endtask

  task automatic push_word2(input logic [31:0] w);
    int n = 0;
    @(posedge clk); #1;
    bus2.in_valid = 1'b1;
    bus2.in_data  = w;
    @(negedge clk);
    while (!bus2.in_ready && n < 500) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    bus2.in_valid = 1'b0;
    if (n >= 500) begin
      checks++; errors++;
      $display("[TB] FAIL dut2 push_timeout: in_ready=0 for %0d cycles, required 1", n);
    end
  endtask

  task automatic wait_drain1();
    int n = 0;
    while ((exp1.size() != 0 || !bus1.idle) && n < 3000) begin @(negedge clk); n++; end
    checks++;
    if (n >= 3000) begin
      errors++;
      $display("[TB] FAIL dut1 drain: %0d bytes outstanding idle=%0b, required 0/1", exp1.size(), bus1.idle);
    end
  endtask

  task automatic wait_drain2();
    int n = 0;
    while ((exp2.size() != 0 || !bus2.idle) && n < 3000) begin @(negedge clk); n++; end
    checks++;
    if (n >= 3000) begin
      errors++;
      $display("[TB] FAIL dut2 drain: %0d bytes outstanding idle=%0b, required 0/1", exp2.size(), bus2.idle);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (bus1.tx_en !== 1'b0) begin errors++; $display("[TB] FAIL reset tx_en: got %b required 0", bus1.tx_en); end
    checks++; if (bus1.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset in_ready: got %b required 1", bus1.in_ready); end
    checks++; if (bus1.tx_data !== 8'h00) begin errors++; $display("[TB] FAIL reset tx_data: got %h required 00", bus1.tx_data); end
    checks++; if (bus1.fifo_level !== 3'd0) begin errors++; $display("[TB] FAIL reset fifo_level: got %0d required 0", bus1.fifo_level); end
    checks++; if (bus1.idle !== 1'b1) begin errors++; $display("[TB] FAIL reset idle: got %b required 1", bus1.idle); end
    checks++; if (bus2.tx_en !== 1'b0 || bus2.idle !== 1'b1) begin errors++; $display("[TB] FAIL reset dut2: tx_en=%b idle=%b required 0/1", bus2.tx_en, bus2.idle); end
    @(posedge clk); #1;
    resetn = 1'b1;
    @(negedge clk);
    checks++; if (bus1.idle !== 1'b1 || bus1.tx_data !== 8'h00) begin errors++; $display("[TB] FAIL post_reset: idle=%b tx_data=%h required 1/00", bus1.idle, bus1.tx_data); end
  endtask

  task automatic test_latency();
    int c0;
    b1_len = 3;
    c0 = en_count1;
    @(posedge clk); #1;
    bus1.in_valid = 1'b1;
    bus1.in_data  = 32'h1234ABCD;
    @(negedge clk);
    checks++; if (bus1.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL latency in_ready: got %b required 1", bus1.in_ready); end
    @(posedge clk); #1;
    bus1.in_valid = 1'b0;
    @(negedge clk);
    checks++; if (bus1.tx_en !== 1'b0 || bus1.fifo_level !== 3'd1 || bus1.idle !== 1'b0) begin
      errors++; $display("[TB] FAIL latency cycle1: tx_en=%b level=%0d idle=%b required 0/1/0", bus1.tx_en, bus1.fifo_level, bus1.idle);
    end
    @(negedge clk);
    checks++; if (bus1.tx_en !== 1'b1 || bus1.tx_data !== 8'h31 || bus1.fifo_level !== 3'd0) begin
      errors++; $display("[TB] FAIL latency cycle2: tx_en=%b data=%h level=%0d required 1/31/0", bus1.tx_en, bus1.tx_data, bus1.fifo_level);
    end
    wait_drain1();
    checks++; if (en_count1 - c0 != 10) begin errors++; $display("[TB] FAIL latency pulses: got %0d required 10", en_count1 - c0); end
  endtask

  task automatic test_back_to_back();
    int b;
    int gap;
    b = int'($urandom_range(1, 5));
    b1_len = b;
    en_times1.delete();
    push_word1(32'h00000000);
    push_word1(32'hFFFFFFFF);
    wait_drain1();
    checks++;
    if (en_times1.size() != 20) begin
      errors++; $display("[TB] FAIL b2b pulses: got %0d required 20", en_times1.size());
    end else begin
      for (int i = 1; i < 20; i++) begin
        gap = (i == 10) ? b + 3 : b + 2;
        checks++;
        if (en_times1[i] - en_times1[i-1] != gap) begin
          errors++; $display("[TB] FAIL b2b spacing[%0d]: got %0d required %0d", i, en_times1[i] - en_times1[i-1], gap);
        end
      end
    end
  endtask

  task automatic test_busy_hold_and_full();
    int accepted = 0;
    int c0;
    int n;
    logic [31:0] words [7];
    for (int k = 0; k < 7; k++) words[k] = $urandom;
    b1_len = 2;
    hold1 = 1'b1;
    repeat (2) @(posedge clk);
    c0 = en_count1;
    for (int k = 0; k < 7; k++) begin
      @(posedge clk); #1;
      bus1.in_valid = 1'b1;
      bus1.in_data  = words[k];
      n = 0;
      @(negedge clk);
      while (!bus1.in_ready && n < 8) begin @(negedge clk); n++; end
      if (n < 8) accepted++;
      @(posedge clk); #1;
      bus1.in_valid = 1'b0;
    end
    @(negedge clk);
    checks++; if (accepted != 5) begin errors++; $display("[TB] FAIL hold accepted: got %0d required 5", accepted); end
    checks++; if (bus1.in_ready !== 1'b0 || bus1.fifo_level !== 3'd4) begin
      errors++; $display("[TB] FAIL hold full: in_ready=%b level=%0d required 0/4", bus1.in_ready, bus1.fifo_level);
    end
    checks++; if (en_count1 != c0 || bus1.tx_en !== 1'b0) begin errors++; $display("[TB] FAIL hold tx_en: got %0d pulses required 0", en_count1 - c0); end

    @(posedge clk); #1;
    bus1.in_valid = 1'b1;
    bus1.in_data  = words[5];
    hold1 = 1'b0;
    n = 0;
    @(negedge clk);
    while (!bus1.in_ready && n < 2000) begin @(negedge clk); n++; end
    checks++;
    if (n >= 2000) begin
      errors++; $display("[TB] FAIL full_pop timeout: in_ready=0, required 1");
    end else if (bus1.fifo_level !== 3'd3) begin
      errors++; $display("[TB] FAIL full_pop level_at_ready: got %0d required 3", bus1.fifo_level);
    end
    @(posedge clk); #1;
    bus1.in_valid = 1'b0;
    @(negedge clk);
    checks++; if (bus1.fifo_level !== 3'd4 || bus1.in_ready !== 1'b0) begin
      errors++; $display("[TB] FAIL full_pop refill: level=%0d in_ready=%b required 4/0", bus1.fifo_level, bus1.in_ready);
    end
    wait_drain1();
    checks++; if (en_count1 - c0 != 60) begin errors++; $display("[TB] FAIL hold pulses: got %0d required 60", en_count1 - c0); end
  endtask

  task automatic test_random_words();
    int c0;
    c0 = en_count1;
    b1_rand = 1'b1;
    for (int k = 0; k < 12; k++) begin
      repeat (int'($urandom_range(0, 3))) @(posedge clk);
      push_word1($urandom);
    end
    wait_drain1();
    b1_rand = 1'b0;
    checks++; if (en_count1 - c0 != 120) begin errors++; $display("[TB] FAIL random pulses: got %0d required 120", en_count1 - c0); end
  endtask

  task automatic test_no_crlf();
    logic [7:0] ref_bytes [8];
    int c0;
    ref_bytes = '{8'h44, 8'h45, 8'h41, 8'h44, 8'h42, 8'h45, 8'h45, 8'h46};
    c0 = en_count2;
    log2.delete();
    push_word2(32'hDEADBEEF);
    push_word2($urandom);
    push_word2($urandom);
    wait_drain2();
    checks++;
    if (en_count2 - c0 != 24) begin
      errors++; $display("[TB] FAIL nocrlf pulses: got %0d required 24", en_count2 - c0);
    end else begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (log2[i] !== ref_bytes[i]) begin
          errors++; $display("[TB] FAIL nocrlf byte[%0d]: got %h required %h", i, log2[i], ref_bytes[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_word();
    int c0;
    int n = 0;
    b1_len = 3;
    c0 = en_count1;
    push_word1($urandom);
    push_word1($urandom);
    push_word1($urandom);
    while (en_count1 - c0 < 3 && n < 500) begin @(negedge clk); n++; end
    checks++;
    if (n >= 500) begin errors++; $display("[TB] FAIL midreset start: got %0d pulses required 3", en_count1 - c0); end
    @(posedge clk); #1;
    resetn = 1'b0;
    @(negedge clk);
    checks++; if (bus1.tx_en !== 1'b0) begin errors++; $display("[TB] FAIL midreset tx_en_pre: got %b required 0", bus1.tx_en); end
    @(negedge clk);
    checks++; if (bus1.tx_en !== 1'b0 || bus1.fifo_level !== 3'd0 || bus1.idle !== 1'b1) begin
      errors++; $display("[TB] FAIL midreset state: tx_en=%b level=%0d idle=%b required 0/0/1", bus1.tx_en, bus1.fifo_level, bus1.idle);
    end
    @(posedge clk); #1;
    resetn = 1'b1;
    c0 = en_count1;
    repeat (60) @(negedge clk);
    checks++; if (en_count1 != c0 || bus1.idle !== 1'b1) begin
      errors++; $display("[TB] FAIL midreset residual: %0d pulses idle=%b required 0/1", en_count1 - c0, bus1.idle);
    end
    push_word1(32'hC0FFEE42);
    wait_drain1();
    checks++; if (en_count1 - c0 != 10) begin errors++; $display("[TB] FAIL midreset recover: got %0d pulses required 10", en_count1 - c0); end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    resetn = 1'b0;
    bus1.in_valid = 1'b0;
    bus1.in_data  = '0;
    bus2.in_valid = 1'b0;
    bus2.in_data  = '0;
    $display("[TB] start");
    test_reset();
    test_latency();
    test_back_to_back();
    test_busy_hold_and_full();
    test_random_words();
    test_no_crlf();
    test_reset_mid_word();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
